// File: rtl/conv1_pool_sink.sv
// Frame buffer between the conv1 pooling stage and the conv2 consumer.
// Captures one 14x14x6 pooled feature map (98 beats) and serves random-access reads.
//
// state   | meaning
// IDLE    | waiting for sof_i, no frame readable
// COLLECT | writing incoming beats at beat_cnt
// FULL    | 98 beats stored, extra beats dropped, waiting for eof_i
// HOLD    | feature map readable until rd_release_i
module conv1_pool_sink (
  input  logic                  conv1_pool_sink_clk,
  input  logic                  conv1_pool_sink_rst_b,
  input  logic [5:0][1:0][21:0] pool_out_i,
  input  logic                  pool_valid_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  input  logic                  rd_en_i,
  input  logic [6:0]            rd_addr_i,
  input  logic                  rd_release_i,
  output logic [263:0]          rd_data_o,
  output logic                  rd_valid_o,
  output logic                  fm_ready_o,
  output logic                  frame_done_o,
  output logic                  ovf_err_o,
  output logic                  short_err_o,
  output logic [6:0]            beat_cnt_o
);

  localparam int unsigned N_BEATS   = 98;
  localparam logic [6:0]  LAST_ADDR = 7'd97;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t         r_state;
  logic [6:0]     r_beat_cnt;
  logic           r_fm_ready;
  logic           r_frame_done;
  logic           r_ovf_err;
  logic           r_short_err;
  logic           r_rd_valid;
  logic [263:0]   r_rd_data;
  logic [263:0]   r_mem [N_BEATS];

  logic           w_wr_en;
  logic [6:0]     w_wr_addr;
  logic           w_cnt_last;
  logic           w_rd_ok;

  assign w_cnt_last = (r_beat_cnt == LAST_ADDR);
  assign w_rd_ok    = rd_en_i && r_fm_ready && (rd_addr_i <= LAST_ADDR);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    if (pool_valid_i) begin
      case (r_state)
        S_IDLE: begin
          if (sof_i) begin
            w_wr_en   = 1'b1;
            w_wr_addr = '0;
          end
        end
        S_COLLECT: begin
          w_wr_en   = 1'b1;
          w_wr_addr = sof_i ? 7'd0 : r_beat_cnt;
        end
        default: ;
      endcase
    end
  end

  // Buffer has no reset; fm_ready gates visibility of stale contents.
  always_ff @(posedge conv1_pool_sink_clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= pool_out_i;
  end

  always_ff @(posedge conv1_pool_sink_clk or negedge conv1_pool_sink_rst_b) begin
    if (!conv1_pool_sink_rst_b) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_fm_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_short_err  <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sof_i) begin
            r_ovf_err   <= 1'b0;
            r_short_err <= 1'b0;
            r_beat_cnt  <= pool_valid_i ? 7'd1 : 7'd0;
            r_state     <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (sof_i) begin
            r_beat_cnt <= pool_valid_i ? 7'd1 : 7'd0;
          end else if (pool_valid_i && w_cnt_last) begin
            r_beat_cnt <= r_beat_cnt + 7'd1;
            if (eof_i) begin
              r_state      <= S_HOLD;
              r_fm_ready   <= 1'b1;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_FULL;
            end
          end else begin
            if (pool_valid_i) r_beat_cnt <= r_beat_cnt + 7'd1;
            if (eof_i) begin
              r_short_err <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          if (pool_valid_i) r_ovf_err <= 1'b1;
          if (eof_i) begin
            r_state      <= S_HOLD;
            r_fm_ready   <= 1'b1;
            r_frame_done <= 1'b1;
          end
        end
        S_HOLD: begin
          if (sof_i) r_ovf_err <= 1'b1;
          if (rd_release_i) begin
            r_state    <= S_IDLE;
            r_fm_ready <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A read issued alongside rd_release_i still sees fm_ready high and completes.
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o    = r_rd_data;
  assign rd_valid_o   = r_rd_valid;
  assign fm_ready_o   = r_fm_ready;
  assign frame_done_o = r_frame_done;
  assign ovf_err_o    = r_ovf_err;
  assign short_err_o  = r_short_err;
  assign beat_cnt_o   = r_beat_cnt;

endmodule

// File: tb/tb_conv1_pool_sink.sv
// Self-checking bench for conv1_pool_sink: frame-level model of what gets stored,
// which flags result from a frame of n beats, and what reads must return.
module tb_conv1_pool_sink;

  logic                  clk = 1'b0;
  logic                  rst_b;
  logic [5:0][1:0][21:0] pool_out;
  logic                  pool_valid, sof, eof, rd_en, rd_release;
  logic [6:0]            rd_addr;
  logic [263:0]          rd_data;
  logic                  rd_valid, fm_ready, frame_done, ovf_err, short_err;
  logic [6:0]            beat_cnt;

  int total = 0;
  int bad   = 0;

  logic [263:0] exp_mem [98];
  logic [263:0] sent [$];

  conv1_pool_sink dut (
    .conv1_pool_sink_clk   (clk),
    .conv1_pool_sink_rst_b (rst_b),
    .pool_out_i            (pool_out),
    .pool_valid_i          (pool_valid),
    .sof_i                 (sof),
    .eof_i                 (eof),
    .rd_en_i               (rd_en),
    .rd_addr_i             (rd_addr),
    .rd_release_i          (rd_release),
    .rd_data_o             (rd_data),
    .rd_valid_o            (rd_valid),
    .fm_ready_o            (fm_ready),
    .frame_done_o          (frame_done),
    .ovf_err_o             (ovf_err),
    .short_err_o           (short_err),
    .beat_cnt_o            (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    pool_out = '0; pool_valid = 0; sof = 0; eof = 0;
    rd_en = 0; rd_addr = '0; rd_release = 0;
  endtask

  function automatic logic [263:0] pat_beat(input int v);
    logic [263:0] b;
    for (int k = 0; k < 12; k++) b[k*22 +: 22] = 22'(v);
    return b;
  endfunction

  function automatic logic [263:0] rnd_beat();
    logic [263:0] b;
    for (int k = 0; k < 12; k++) b[k*22 +: 22] = 22'($urandom);
    return b;
  endfunction

  // sof on its own cycle, then n consecutive beats; the buffer keeps the first 98
  task automatic send_frame(input int n, input bit use_pat);
    logic [263:0] b;
    sent.delete();
    sof = 1; tick(); sof = 0;
    for (int i = 0; i < n; i++) begin
      b = use_pat ? pat_beat(i) : rnd_beat();
      sent.push_back(b);
      pool_out = b; pool_valid = 1;
      tick();
    end
    pool_valid = 0; pool_out = '0;
    for (int i = 0; i < n && i < 98; i++) exp_mem[i] = sent[i];
  endtask

  task automatic read_one(input logic [6:0] a);
    rd_en = 1; rd_addr = a; tick(); rd_en = 0;
  endtask

  task automatic test_reset();
    clear_in();
    rst_b = 0;
    repeat (3) tick();
    total++; if (rd_data !== '0)     begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (fm_ready !== 1'b0)  begin bad++; $display("FAIL reset_fm_ready got=%b exp=0", fm_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (ovf_err !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    total++; if (short_err !== 1'b0) begin bad++; $display("FAIL reset_short got=%b exp=0", short_err); end
    total++; if (beat_cnt !== 7'd0)  begin bad++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
    rst_b = 1;
    tick();
  endtask

  task automatic test_normal();
    send_frame(98, 1'b1);
    total++; if (beat_cnt !== 7'd98) begin bad++; $display("FAIL normal_cnt got=%0d exp=98", beat_cnt); end
    total++; if (fm_ready !== 1'b0)  begin bad++; $display("FAIL normal_ready_early got=%b exp=0", fm_ready); end
    eof = 1; tick(); eof = 0;
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL normal_done got=%b exp=1", frame_done); end
    total++; if (fm_ready !== 1'b1)   begin bad++; $display("FAIL normal_ready got=%b exp=1", fm_ready); end
    total++; if (short_err !== 1'b0 || ovf_err !== 1'b0)
      begin bad++; $display("FAIL normal_errs got=%b%b exp=00", ovf_err, short_err); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL normal_done_pulse got=%b exp=0", frame_done); end
    read_one(7'd37);
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL normal_rd37_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== pat_beat(37)) begin bad++; $display("FAIL normal_rd37 got=%h exp=%h", rd_data, pat_beat(37)); end
  endtask

  task automatic test_back_to_back();
    int unsigned a;
    rd_en = 1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 97);
      rd_addr = 7'(a);
      tick();
      total++; if (rd_valid !== 1'b1 || rd_data !== exp_mem[a])
        begin bad++; $display("FAIL b2b_read addr=%0d got=%b/%h exp=1/%h", a, rd_valid, rd_data, exp_mem[a]); end
    end
    rd_en = 0;
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_hold_ignore();
    pool_valid = 1; pool_out = rnd_beat(); sof = 1; rd_en = 0;
    tick();
    clear_in();
    total++; if (ovf_err !== 1'b1)   begin bad++; $display("FAIL hold_sof_ovf got=%b exp=1", ovf_err); end
    total++; if (fm_ready !== 1'b1)  begin bad++; $display("FAIL hold_ready got=%b exp=1", fm_ready); end
    total++; if (beat_cnt !== 7'd98) begin bad++; $display("FAIL hold_cnt got=%0d exp=98", beat_cnt); end
    read_one(7'd0);
    total++; if (rd_data !== exp_mem[0]) begin bad++; $display("FAIL hold_nowrite got=%h exp=%h", rd_data, exp_mem[0]); end
    rd_en = 1; rd_addr = 7'd5; rd_release = 1;
    tick();
    clear_in();
    total++; if (rd_valid !== 1'b1 || rd_data !== exp_mem[5])
      begin bad++; $display("FAIL release_read got=%b/%h exp=1/%h", rd_valid, rd_data, exp_mem[5]); end
    total++; if (fm_ready !== 1'b0) begin bad++; $display("FAIL release_ready got=%b exp=0", fm_ready); end
  endtask

  task automatic test_short();
    logic [263:0] held;
    held = rd_data;
    send_frame(50, 1'b0);
    total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL short_ovf_cleared got=%b exp=0", ovf_err); end
    eof = 1; tick(); eof = 0;
    total++; if (short_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", short_err); end
    total++; if (fm_ready !== 1'b0 || frame_done !== 1'b0)
      begin bad++; $display("FAIL short_ready got=%b%b exp=00", fm_ready, frame_done); end
    total++; if (beat_cnt !== 7'd50) begin bad++; $display("FAIL short_cnt got=%0d exp=50", beat_cnt); end
    pool_valid = 1; pool_out = rnd_beat(); tick(); clear_in();
    total++; if (beat_cnt !== 7'd50) begin bad++; $display("FAIL short_idle_cnt got=%0d exp=50", beat_cnt); end
    read_one(7'd3);
    total++; if (rd_valid !== 1'b0 || rd_data !== held)
      begin bad++; $display("FAIL short_read_blocked got=%b/%h exp=0/%h", rd_valid, rd_data, held); end
  endtask

  task automatic test_overflow();
    logic [263:0] held;
    send_frame(100, 1'b0);
    total++; if (ovf_err !== 1'b1)   begin bad++; $display("FAIL ovf_err got=%b exp=1", ovf_err); end
    total++; if (short_err !== 1'b0) begin bad++; $display("FAIL ovf_short_cleared got=%b exp=0", short_err); end
    total++; if (beat_cnt !== 7'd98) begin bad++; $display("FAIL ovf_cnt_sat got=%0d exp=98", beat_cnt); end
    eof = 1; tick(); eof = 0;
    total++; if (frame_done !== 1'b1 || fm_ready !== 1'b1)
      begin bad++; $display("FAIL ovf_done got=%b%b exp=11", frame_done, fm_ready); end
    read_one(7'd97);
    total++; if (rd_valid !== 1'b1 || rd_data !== sent[97])
      begin bad++; $display("FAIL ovf_entry97 got=%b/%h exp=1/%h", rd_valid, rd_data, sent[97]); end
    held = rd_data;
    read_one(7'd120);
    total++; if (rd_valid !== 1'b0 || rd_data !== held)
      begin bad++; $display("FAIL ovf_addr120 got=%b/%h exp=0/%h", rd_valid, rd_data, held); end
    rd_release = 1; tick(); rd_release = 0;
    sof = 1; tick(); sof = 0;
    total++; if (ovf_err !== 1'b0 || short_err !== 1'b0)
      begin bad++; $display("FAIL ovf_errs_cleared got=%b%b exp=00", ovf_err, short_err); end
  endtask

  task automatic test_midreset();
    send_frame(40, 1'b0);
    total++; if (beat_cnt !== 7'd40) begin bad++; $display("FAIL mid_cnt got=%0d exp=40", beat_cnt); end
    #2 rst_b = 0;
    #1;
    total++; if (beat_cnt !== 7'd0 || fm_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 ||
                 ovf_err !== 1'b0 || short_err !== 1'b0 || frame_done !== 1'b0)
      begin bad++; $display("FAIL mid_reset_outs cnt=%0d rdy=%b vld=%b err=%b%b done=%b exp all 0",
                            beat_cnt, fm_ready, rd_valid, ovf_err, short_err, frame_done); end
    tick();
    rst_b = 1;
    tick();
    send_frame(98, 1'b0);
    eof = 1; tick(); eof = 0;
    total++; if (frame_done !== 1'b1 || fm_ready !== 1'b1 || short_err !== 1'b0 || ovf_err !== 1'b0)
      begin bad++; $display("FAIL mid_frame_after got=%b%b%b%b exp=1100", frame_done, fm_ready, short_err, ovf_err); end
    test_back_to_back();
    rd_release = 1; tick(); rd_release = 0;
  endtask

  task automatic test_sof_valid();
    logic [263:0] b;
    b = rnd_beat();
    sof = 1; pool_valid = 1; pool_out = b; tick(); clear_in();
    total++; if (beat_cnt !== 7'd1) begin bad++; $display("FAIL sofv_idle_cnt got=%0d exp=1", beat_cnt); end
    for (int i = 0; i < 10; i++) begin pool_valid = 1; pool_out = rnd_beat(); tick(); end
    b = rnd_beat();
    sof = 1; pool_valid = 1; pool_out = b; tick(); clear_in();
    total++; if (beat_cnt !== 7'd1) begin bad++; $display("FAIL sofv_restart_cnt got=%0d exp=1", beat_cnt); end
    exp_mem[0] = b;
    for (int i = 1; i < 98; i++) begin
      exp_mem[i] = rnd_beat();
      pool_valid = 1; pool_out = exp_mem[i]; tick();
    end
    clear_in();
    eof = 1; tick(); eof = 0;
    total++; if (fm_ready !== 1'b1) begin bad++; $display("FAIL sofv_ready got=%b exp=1", fm_ready); end
    read_one(7'd0);
    total++; if (rd_data !== b) begin bad++; $display("FAIL sofv_addr0 got=%h exp=%h", rd_data, b); end
    read_one(7'd1);
    total++; if (rd_data !== exp_mem[1]) begin bad++; $display("FAIL sofv_addr1 got=%h exp=%h", rd_data, exp_mem[1]); end
  endtask

  initial begin
    rst_b = 0;
    clear_in();
    test_reset();
    test_normal();
    test_back_to_back();
    test_hold_ignore();
    test_short();
    test_overflow();
    test_midreset();
    test_sof_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
